// File: rtl/fir_pkg.sv
// Shared definitions for the FIR chain: default sample format and the
// rounding helper used by the decimator and the other filter stages.
package fir_pkg;
    localparam int WI_DEF = 2;
    localparam int WF_DEF = 6;
    localparam int W_DEF  = WI_DEF + WF_DEF;

    // Half an output LSB after dividing by 2^dec_log2 (round half toward +inf)
    function automatic int rnd_const(input int dec_log2);
        return 1 << (dec_log2 - 1);
    endfunction
endpackage

// File: rtl/fir_decimator_if.sv
// Sample-in / result-out handshake bundle of the decimator.
interface fir_decimator_if
    import fir_pkg::*;
#(
    parameter int W = W_DEF
);
    logic         in_valid;
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         out_valid;
    logic         out_ready;
    logic         ovf;
    logic         clr_ovf;

    modport master (output in_valid, x, out_ready, clr_ovf,
                    input  y, out_valid, ovf);
    modport slave  (input  in_valid, x, out_ready, clr_ovf,
                    output y, out_valid, ovf);
endinterface

// File: rtl/sync_fifo_sa.sv
// Show-ahead synchronous FIFO; a push on a full FIFO is taken only when a pop
// frees the head in the same cycle.
module sync_fifo_sa
    import fir_pkg::*;
#(
    parameter int DW = W_DEF,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [DW-1:0] data_i,
    input  logic          pop_i,
    output logic [DW-1:0] data_o,
    output logic          full_o,
    output logic          empty_o
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          wr_en, rd_en;

    assign full_o  = (cnt_q == (AW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    // Head reads as zero while empty so the output is clean after reset
    assign data_o  = empty_o ? '0 : mem_q[rd_q];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (wr_en) wr_q <= wr_q + 1'b1;
            if (rd_en) rd_q <= rd_q + 1'b1;
            case ({wr_en, rd_en})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_q] <= data_i;
    end
endmodule

// File: rtl/fir_decimator.sv
// Integrate-and-dump decimator: averages 2^DEC_LOG2 FIR samples with
// round-half-up and queues the means in a show-ahead FIFO.
module fir_decimator
    import fir_pkg::*;
#(
    parameter int WI         = WI_DEF,
    parameter int WF         = WF_DEF,
    parameter int DEC_LOG2   = 2,
    parameter int DEPTH_LOG2 = 2
) (
    input  logic          clk,
    input  logic          rst,
    fir_decimator_if.slave io
);
    localparam int W   = WI + WF;
    localparam int SW  = W + DEC_LOG2;
    localparam int RND = rnd_const(DEC_LOG2);

    logic [DEC_LOG2-1:0] ph_q, ph_d;
    logic [SW-1:0]       acc_q, acc_d;
    logic                ovf_q, ovf_d;
    logic [SW:0]         sum, rsum;
    logic [W-1:0]        r;
    logic                dump, pop, full, empty;
    logic                unused_rbits;

    assign dump = io.in_valid && (&ph_q);
    assign pop  = io.out_valid && io.out_ready;
    // Sign-extend both operands one bit past the accumulator width
    assign sum  = {{(DEC_LOG2+1){io.x[W-1]}}, io.x} + {acc_q[SW-1], acc_q};
    assign rsum = sum + (SW+1)'(RND);
    // Arithmetic shift then truncate to W bits is exactly this slice
    assign r    = rsum[DEC_LOG2 +: W];
    assign unused_rbits = ^{rsum[DEC_LOG2-1:0], rsum[SW]};

    always_comb begin
        ph_d  = ph_q;
        acc_d = acc_q;
        if (io.in_valid) begin
            if (dump) begin
                ph_d  = '0;
                acc_d = '0;
            end else begin
                ph_d  = ph_q + 1'b1;
                acc_d = sum[SW-1:0];
            end
        end
        ovf_d = ovf_q;
        if (io.clr_ovf)              ovf_d = 1'b0;
        if (dump && full && !pop)    ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ph_q  <= '0;
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            ph_q  <= ph_d;
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    sync_fifo_sa #(.DW(W), .AW(DEPTH_LOG2)) u_fifo (
        .clk    (clk),
        .rst_n  (rst),
        .push_i (dump),
        .data_i (r),
        .pop_i  (pop),
        .data_o (io.y),
        .full_o (full),
        .empty_o(empty)
    );

    assign io.out_valid = !empty;
    assign io.ovf       = ovf_q;
endmodule

// File: tb/tb_fir_decimator.sv
// Directed bench for fir_decimator (N=4, 4-deep FIFO, Q2.6 samples).
module tb_fir_decimator;
    import fir_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    fir_decimator_if #(.W(8)) bus ();

    fir_decimator #(.WI(2), .WF(6), .DEC_LOG2(2), .DEPTH_LOG2(2)) dut (
        .clk(clk),
        .rst(rst),
        .io (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic smp(input logic [7:0] v);
        bus.in_valid = 1'b1;
        bus.x        = v;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic blk(input string tag, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d, input logic [7:0] e);
        bus.out_ready = 1'b1;
        smp(a); smp(b); smp(c); smp(d);
        chk({tag, " vld"}, 16'(bus.out_valid), 16'd1);
        chk(tag, 16'(bus.y), 16'(e));
        tick();
        chk({tag, " pop"}, 16'(bus.out_valid), 16'd0);
    endtask

    task automatic fill(input logic [7:0] v);
        for (int j = 0; j < 4; j++) smp(v);
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.out_ready = 1'b0;
        bus.clr_ovf   = 1'b0;
        #1 rst = 1'b0;
        tick();
        tick();
        chk("rst vld", 16'(bus.out_valid), 16'd0);
        chk("rst y",   16'(bus.y),         16'd0);
        chk("rst ovf", 16'(bus.ovf),       16'd0);
        rst = 1'b1;

        // Constant 1.0 stream, consumer always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            smp(8'h40);
            chk("const vld", 16'(bus.out_valid), 16'((i % 4) == 3));
            if ((i % 4) == 3) chk("const y", 16'(bus.y), 16'h0040);
        end

        blk("rnd 1100",  8'h01, 8'h01, 8'h00, 8'h00, 8'h01);
        blk("rnd 1000",  8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
        blk("rnd -1-1",  8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00);
        blk("rnd -3",    8'hFD, 8'h00, 8'h00, 8'h00, 8'hFF);
        blk("rnd -2-1",  8'hFE, 8'hFF, 8'hFF, 8'hFF, 8'hFF);
        blk("max",       8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F);
        blk("min",       8'h80, 8'h80, 8'h80, 8'h80, 8'h80);
        blk("mix",       8'h7F, 8'h7F, 8'h80, 8'h80, 8'h00);

        // Backpressure: fifth result dropped
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            fill(8'(k));
            if (k == 4) begin
                chk("bp ovf4", 16'(bus.ovf),       16'd0);
                chk("bp vld4", 16'(bus.out_valid), 16'd1);
                chk("bp y4",   16'(bus.y),         16'd1);
            end
        end
        chk("bp ovf5", 16'(bus.ovf), 16'd1);
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            chk("bp drain", 16'(bus.y), 16'(k));
            tick();
        end
        chk("bp empty",  16'(bus.out_valid), 16'd0);
        chk("bp sticky", 16'(bus.ovf),       16'd1);
        bus.clr_ovf = 1'b1;
        tick();
        bus.clr_ovf = 1'b0;
        chk("bp clr", 16'(bus.ovf), 16'd0);

        // Full FIFO, pop coincides with the dump
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 4; k++) fill(8'(k));
        smp(8'h05); smp(8'h05); smp(8'h05);
        bus.out_ready = 1'b1;
        smp(8'h05);
        bus.out_ready = 1'b0;
        chk("fp ovf", 16'(bus.ovf),       16'd0);
        chk("fp vld", 16'(bus.out_valid), 16'd1);
        bus.out_ready = 1'b1;
        for (int k = 2; k <= 5; k++) begin
            chk("fp drain", 16'(bus.y), 16'(k));
            tick();
        end
        chk("fp empty", 16'(bus.out_valid), 16'd0);

        // Gaps in in_valid do not break the block
        for (int c = 0; c < 10; c++) begin
            if (c == 0 || c == 3 || c == 4 || c == 9) smp(8'h10);
            else tick();
            chk("gap vld", 16'(bus.out_valid), 16'(c == 9));
            if (c == 9) chk("gap y", 16'(bus.y), 16'h0010);
        end
        tick();

        // Reset mid-block with queued results and ovf set
        bus.out_ready = 1'b0;
        for (int k = 0; k < 5; k++) fill(8'h20);
        chk("pre-rst ovf", 16'(bus.ovf), 16'd1);
        smp(8'h7F); smp(8'h7F);
        rst = 1'b0;
        #2;
        chk("mrst vld", 16'(bus.out_valid), 16'd0);
        chk("mrst y",   16'(bus.y),         16'd0);
        chk("mrst ovf", 16'(bus.ovf),       16'd0);
        tick();
        rst = 1'b1;
        bus.out_ready = 1'b1;
        smp(8'h08); smp(8'h08); smp(8'h08);
        chk("post-rst early", 16'(bus.out_valid), 16'd0);
        smp(8'h08);
        chk("post-rst vld", 16'(bus.out_valid), 16'd1);
        chk("post-rst y",   16'(bus.y),         16'h0008);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/fir_decimator.md
# fir_decimator

Downstream consumer of the 3-tap FIR output stream. Takes the signed Q(WI.WF) filter output one sample per qualified cycle, integrates 2^DEC_LOG2 samples, and dumps the rounded mean (same Q format) into a small show-ahead FIFO. Results are drained through a valid/ready handshake. FIFO overflow drops the result and sets a sticky flag.

## Interface
- `WI`, 2, integer bits of input/output sample (incl. sign)
- `WF`, 6, fractional bits of input/output sample
- `DEC_LOG2`, 2, log2 of decimation factor N (N = 4 by default); legal 1..6
- `DEPTH_LOG2`, 2, log2 of output FIFO depth (4 entries by default)

- `clk`  in  1  single clock, rising edge
- `rst`  in  1  reset, asynchronous assert, active-low
- `in_valid`  in  1  `x` is a new filter sample this cycle
- `x`  in  WI+WF  signed Q(WI.WF) sample from the FIR
- `y`  out  WI+WF  signed Q(WI.WF) decimated sample, FIFO head
- `out_valid`  out  1  `y` holds a result (FIFO non-empty)
- `out_ready`  in  1  consumer accepts `y` this cycle
- `ovf`  out  1  sticky: at least one result dropped on a full FIFO
- `clr_ovf`  in  1  synchronous clear of `ovf`

## Operation
- Phase counter `ph` (DEC_LOG2 bits) and accumulator `acc` (signed, W+DEC_LOG2 bits, W = WI+WF).
- `in_valid` = 0: no state change in counter or accumulator. Gaps are allowed and do not break a block.
- `in_valid` = 1 with `ph` < N-1: `acc <= acc + x`, `ph <= ph+1`.
- `in_valid` = 1 with `ph` = N-1 (dump): form `s = acc + x` in W+DEC_LOG2+1 bits. Result is `r = (s + 2^(DEC_LOG2-1)) >>> DEC_LOG2` (round half toward +inf), truncated to W bits. Then `acc <= 0` and `ph <= 0`.
- `r` always fits in W bits, because the mean of in-range samples rounded this way stays in range. No saturation logic is required.
- Push `r` into the FIFO on the dump edge.
- FIFO full at dump:
  - If a pop happens in the same cycle, the push is accepted.
  - Otherwise `r` is discarded and `ovf <= 1`.
  - The accumulator restarts regardless.
- Pop when `out_valid && out_ready`. The FIFO is show-ahead: `y` is the oldest entry whenever `out_valid` = 1.
- `y` is held stable while `out_valid && !out_ready`.
- `ovf` set and `clr_ovf` in the same cycle: set wins.
- Pop on an empty FIFO is ignored.

## Timing
- Reset (`rst` low) asynchronously clears:
  - `ph` and `acc`
  - FIFO pointers and count
  - `y` = 0, `out_valid` = 0, `ovf` = 0
- Reset mid-block discards the partial sum and all queued results.
- Latency: for a dump sample captured at edge k, `out_valid` is high after edge k (visible the cycle after the Nth sample is presented) if the FIFO was empty.
- Throughput: one input per cycle sustained. One output per N inputs.
- Simultaneous push and pop on a non-empty FIFO: the count is unchanged. The head advances to the next-oldest entry.
- Simultaneous push and pop on an empty FIFO is impossible, because pop requires `out_valid`.
- Pointer wrap-around modulo 2^DEPTH_LOG2. Full/empty are distinguished by a DEPTH_LOG2+1-bit count.

## Structure
- Shared package `fir_pkg`:
  - default WI/WF
  - sample width localparam
  - rounding-constant helper (`2^(DEC_LOG2-1)`)
  - shared with the FIR and multiplier/adder stages
- Sub-module `sync_fifo_sa`: parameterised width/depth show-ahead FIFO.
  - Ports: push/pop/data, full/empty.
  - Async active-low reset.
- The top level holds the counter, accumulator, rounding and overflow flag.

## Test plan
- Constant stream `x` = 8'h40 (1.0), `in_valid` = 1, `out_ready` = 1 -> `y` = 8'h40 with `out_valid` high for one cycle every 4 cycles. First `out_valid` appears the cycle after the 4th sample.
- Rounding, in LSB units:
  - {1,1,0,0} -> 1
  - {1,0,0,0} -> 0
  - {-1,-1,0,0} -> 0
  - {-3,0,0,0} -> -1 (8'hFF)
  - {-2,-1,-1,-1} -> -1
- Extremes: 4×8'h7F -> 8'h7F; 4×8'h80 -> 8'h80; {7F,7F,80,80} -> 8'h00.
- Backpressure: `out_ready` = 0, feed 5 blocks of constants 1..5 -> FIFO holds 1,2,3,4, block 5 is dropped, and `ovf` rises on the 5th dump edge. Then `out_ready` = 1 drains 1,2,3,4 in order and `ovf` stays 1 until `clr_ovf`.
- Full FIFO with pop on the dump cycle -> push accepted, no `ovf`, order preserved.
- `in_valid` gaps, e.g. samples 8'h10 on cycles 0, 3, 4, 9 -> one result 8'h10 after cycle 9. Reset pulse after 2 samples -> all outputs 0, and the next 4 samples produce a fresh mean unaffected by the earlier ones.
